pfd_tdc_ctrl: RTL and testbench



---
 rtl/pfd_tdc_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pfd_tdc_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pfd_tdc_ctrl.sv
// Interval TDC: counts dco_clk cycles between two muxed, synchronised edges.
// Result averaging is built only when the TDC_AVG_EN macro is defined.
module pfd_tdc_ctrl #(
  parameter int CNT_W      = 13,
  parameter int SAT_MAX    = 8190,
  parameter int COARSE_DIV = 280,
  parameter int MED_STEPS  = 8,
  parameter int CO_W       = 5,
  parameter int HOLD_CYC   = 3,
  parameter int AVG_LOG2   = 2
) (
  input  logic                 dco_clk,
  input  logic                 reset,
  input  logic                 enable_PFD_TDC,
  input  logic                 select_PFD_input,
  input  logic                 ref_clk,
  input  logic                 external1,
  input  logic                 gated_dco_clk,
  input  logic                 external2,
  output logic                 early,
  output logic [CNT_W-1:0]     count_out,
  output logic [CO_W-1:0]      coarse,
  output logic [MED_STEPS-1:0] bs,
  output logic                 meas_valid,
  output logic                 fine_done_pre,
  output logic                 overflow,
  output logic [CNT_W-1:0]     avg_count,
  output logic                 avg_valid,
  output logic [1:0]           fsm_state
);

  // meas_valid / avg_valid are one-cycle strobes with no ready: the result
  // outputs change on the strobe cycle and stay stable until the next one.

  localparam int HW     = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam int MW     = (MED_STEPS > 1) ? $clog2(MED_STEPS) : 1;
  localparam int PW     = CNT_W + MW + 1;
  localparam int CO_MAX = (1 << CO_W) - 1;
  localparam logic [MED_STEPS-1:0] BS_RST = MED_STEPS'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2, HOLD = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             first_q, first_d;
  logic             sel_q;
  logic [2:0]       sync1_q, sync2_q;
  logic             edge1_in, edge2_in, det1, det2;

  logic             capture, start;
  logic [CNT_W-1:0] cap_val;
  logic             cap_early, cap_ovf;

  logic [CNT_W-1:0]     res_coarse, res_rem;
  logic [PW-1:0]        med_prod;
  logic [MW-1:0]        med_idx;
  logic [CO_W-1:0]      coarse_d;
  logic [MED_STEPS-1:0] bs_d;

  // Source select is frozen outside IDLE so a measurement never changes inputs.
  assign edge1_in = sel_q ? external1 : ref_clk;
  assign edge2_in = sel_q ? external2 : gated_dco_clk;
  assign det1     = sync1_q[1] & ~sync1_q[2];
  assign det2     = sync2_q[1] & ~sync2_q[2];

  assign meas_valid = (state_q == DONE);
  assign fsm_state  = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    first_d   = first_q;
    capture   = 1'b0;
    start     = 1'b0;
    cap_val   = '0;
    cap_early = 1'b0;
    cap_ovf   = 1'b0;
    if (!enable_PFD_TDC) begin
      state_d = IDLE;
      cnt_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (det1 && det2) begin
            capture   = 1'b1;
            cap_early = 1'b1;
            state_d   = DONE;
          end else if (det1 || det2) begin
            start   = 1'b1;
            cnt_d   = CNT_W'(1);
            first_d = det1;
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (first_q ? det2 : det1) begin
            capture   = 1'b1;
            cap_val   = cnt_q;
            cap_early = first_q;
            state_d   = DONE;
          end else if (cnt_q >= CNT_W'(SAT_MAX)) begin
            capture   = 1'b1;
            cap_val   = CNT_W'(SAT_MAX);
            cap_early = first_q;
            cap_ovf   = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          cnt_d   = '0;
          hold_d  = '0;
          state_d = HOLD;
        end
        HOLD: begin
          if (hold_q == HW'(HOLD_CYC - 1)) state_d = IDLE;
          else hold_d = hold_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Coarse step and one-hot medium position of the value being captured.
  always_comb begin
    res_coarse = cap_val / CNT_W'(COARSE_DIV);
    res_rem    = cap_val % CNT_W'(COARSE_DIV);
    med_prod   = PW'(res_rem) * PW'(MED_STEPS);
    med_idx    = MW'(med_prod / PW'(COARSE_DIV));
    coarse_d   = (res_coarse > CNT_W'(CO_MAX)) ? CO_W'(CO_MAX) : CO_W'(res_coarse);
    bs_d          = '0;
    bs_d[med_idx] = 1'b1;
  end

  always_ff @(posedge dco_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      first_q       <= 1'b0;
      sel_q         <= 1'b0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      count_out     <= '0;
      coarse        <= '0;
      bs            <= BS_RST;
      early         <= 1'b0;
      overflow      <= 1'b0;
      fine_done_pre <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      first_q <= first_d;
      sync1_q <= {sync1_q[1:0], edge1_in};
      sync2_q <= {sync2_q[1:0], edge2_in};
      if (state_q == IDLE) sel_q <= select_PFD_input;
      if (capture) begin
        count_out     <= cap_val;
        coarse        <= coarse_d;
        bs            <= bs_d;
        early         <= cap_early;
        overflow      <= cap_ovf;
        fine_done_pre <= 1'b1;
      end else if (start) begin
        fine_done_pre <= 1'b0;
      end
    end
  end

`ifdef TDC_AVG_EN
  logic [CNT_W+AVG_LOG2-1:0] acc_q, acc_sum;
  logic [AVG_LOG2:0]         nres_q;
  logic                      avg_hit_q;

  assign acc_sum   = acc_q + (CNT_W+AVG_LOG2)'(cap_val);
  assign avg_valid = meas_valid & avg_hit_q;

  always_ff @(posedge dco_clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      nres_q    <= '0;
      avg_hit_q <= 1'b0;
      avg_count <= '0;
    end else begin
      avg_hit_q <= 1'b0;
      if (capture) begin
        if (nres_q == (AVG_LOG2+1)'((1 << AVG_LOG2) - 1)) begin
          avg_count <= CNT_W'(acc_sum >> AVG_LOG2);
          acc_q     <= '0;
          nres_q    <= '0;
          avg_hit_q <= 1'b1;
        end else begin
          acc_q  <= acc_sum;
          nres_q <= nres_q + 1'b1;
        end
      end
    end
  end
`else
  assign avg_count = '0;
  assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_tdc_ctrl.sv
// Self-checking bench for pfd_tdc_ctrl: directed scenarios plus random intervals
// compared against an arithmetic reference of the measurement rules.
`timescale 1ns/1ps
module tb_pfd_tdc_ctrl;
  localparam int CNT_W      = 13;
  localparam int SAT_MAX    = 8190;
  localparam int COARSE_DIV = 280;
  localparam int MED_STEPS  = 8;
  localparam int CO_W       = 5;
  localparam int HOLD_CYC   = 3;
  localparam int AVG_DEPTH  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic en = 1'b1, sel = 1'b0;
  logic ref_clk = 1'b0, ext1 = 1'b0, gdco = 1'b0, ext2 = 1'b0;
  logic early, meas_valid, fdp, overflow, avg_valid;
  logic [CNT_W-1:0] count_out, avg_count;
  logic [CO_W-1:0] coarse;
  logic [MED_STEPS-1:0] bs;
  logic [1:0] fsm_state;

  int n_cmp = 0, n_err = 0;
  int mv_cnt = 0;
  int avg_acc = 0, avg_n = 0;

  pfd_tdc_ctrl dut (
    .dco_clk(clk), .reset(rst), .enable_PFD_TDC(en), .select_PFD_input(sel),
    .ref_clk(ref_clk), .external1(ext1), .gated_dco_clk(gdco), .external2(ext2),
    .early(early), .count_out(count_out), .coarse(coarse), .bs(bs),
    .meas_valid(meas_valid), .fine_done_pre(fdp), .overflow(overflow),
    .avg_count(avg_count), .avg_valid(avg_valid), .fsm_state(fsm_state)
  );

  always @(posedge clk) if (meas_valid) mv_cnt <= mv_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // reference arithmetic
  function automatic int exp_coarse(input int c);
    int q;
    q = c / COARSE_DIV;
    return (q > (1 << CO_W) - 1) ? (1 << CO_W) - 1 : q;
  endfunction

  function automatic int exp_bs(input int c);
    return 1 << (((c % COARSE_DIV) * MED_STEPS) / COARSE_DIV);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_edge(input bit which1, input logic v);
    if (which1) begin
      if (sel) ext1 = v; else ref_clk = v;
    end else begin
      if (sel) ext2 = v; else gdco = v;
    end
  endtask

  task automatic lower_all();
    ref_clk = 1'b0; ext1 = 1'b0; gdco = 1'b0; ext2 = 1'b0;
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (meas_valid) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  // scoreboard check on the meas_valid cycle
  task automatic check_result(input int exp_cnt, input bit exp_early, input bit exp_ovf);
    check("count_out", count_out, exp_cnt);
    check("early", early, exp_early);
    check("overflow", overflow, exp_ovf);
    check("coarse", coarse, exp_coarse(exp_cnt));
    check("bs", bs, exp_bs(exp_cnt));
    check("fine_done_pre_set", fdp, 1);
`ifdef TDC_AVG_EN
    avg_acc += exp_cnt;
    avg_n++;
    if (avg_n == AVG_DEPTH) begin
      check("avg_valid", avg_valid, 1);
      check("avg_count", avg_count, avg_acc / AVG_DEPTH);
      avg_acc = 0;
      avg_n = 0;
    end else begin
      check("avg_valid", avg_valid, 0);
    end
`else
    check("avg_valid", avg_valid, 0);
    check("avg_count", avg_count, 0);
`endif
    @(posedge clk); #1;
    check("meas_valid_width", meas_valid, 0);
  endtask

  // gap > 0: second edge gap cycles later; gap == 0: simultaneous; gap < 0: no second edge
  task automatic measure(input logic sel_v, input bit first1, input int gap);
    int mv0, exp_cnt, loops;
    bit found, exp_ovf, exp_early;
    @(negedge clk);
    sel = sel_v;
    repeat (3) @(negedge clk);
    mv0 = mv_cnt;
    drive_edge(first1, 1'b1);
    if (gap == 0) begin
      drive_edge(!first1, 1'b1);
    end else begin
      loops = (gap > 0) ? gap : 6;
      for (int i = 0; i < loops; i++) begin
        @(negedge clk);
        if (i == 4) check("fdp_clear_on_start", fdp, 0);
      end
      if (gap > 0) drive_edge(!first1, 1'b1);
    end
    exp_ovf   = (gap < 0);
    exp_cnt   = (gap < 0) ? SAT_MAX : gap;
    exp_early = (gap == 0) ? 1'b1 : first1;
    wait_valid(found);
    check("valid_seen", found, 1);
    check_result(exp_cnt, exp_early, exp_ovf);
    @(negedge clk);
    lower_all();
    repeat (HOLD_CYC + 8) @(negedge clk);
    check("one_valid", mv_cnt - mv0, 1);
    check("count_held", count_out, exp_cnt);
  endtask

  initial begin
    int mv0;
    bit found;
    repeat (3) @(negedge clk);
    check("rst_count_out", count_out, 0);
    check("rst_coarse", coarse, 0);
    check("rst_bs", bs, 1);
    check("rst_early", early, 0);
    check("rst_overflow", overflow, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_fdp", fdp, 0);
    check("rst_avg_count", avg_count, 0);
    check("rst_avg_valid", avg_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    measure(1'b0, 1'b1, 100);
    measure(1'b1, 1'b0, 600);
    measure(1'b0, 1'b1, 0);
    measure(1'b1, 1'b1, 1);
    measure(1'b0, 1'b1, -1);

    // second edge re-rises while in HOLD: must be ignored
    @(negedge clk); sel = 1'b0;
    repeat (3) @(negedge clk);
    mv0 = mv_cnt;
    ref_clk = 1'b1;
    repeat (30) @(negedge clk);
    gdco = 1'b1;
    @(negedge clk); gdco = 1'b0;
    @(negedge clk); gdco = 1'b1;
    wait_valid(found);
    check("hold_valid_seen", found, 1);
    check_result(30, 1'b1, 1'b0);
    @(negedge clk);
    lower_all();
    repeat (HOLD_CYC + 8) @(negedge clk);
    check("hold_one_valid", mv_cnt - mv0, 1);
    check("hold_fdp_kept", fdp, 1);
    check("hold_count_held", count_out, 30);

    // enable dropped mid-count
    mv0 = mv_cnt;
    ref_clk = 1'b1;
    repeat (40) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    gdco = 1'b1;
    repeat (8) @(negedge clk);
    check("en_no_valid", mv_cnt - mv0, 0);
    check("en_count_held", count_out, 30);
    check("en_fdp", fdp, 0);
    lower_all();
    en = 1'b1;
    repeat (6) @(negedge clk);
    measure(1'b1, 1'b0, 15);

    for (int k = 0; k < 6; k++)
      measure(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 1200));

    // reset about 50 cycles into COUNT
    @(negedge clk); sel = 1'b0;
    repeat (3) @(negedge clk);
    mv0 = mv_cnt;
    ref_clk = 1'b1;
    repeat (53) @(negedge clk);
    #2 rst = 1'b1;
    #1 lower_all();
    check("mid_rst_count_out", count_out, 0);
    check("mid_rst_coarse", coarse, 0);
    check("mid_rst_bs", bs, 1);
    check("mid_rst_early", early, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_fdp", fdp, 0);
    check("mid_rst_avg_count", avg_count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    avg_acc = 0;
    avg_n = 0;
    repeat (6) @(negedge clk);
    check("mid_rst_no_valid", mv_cnt - mv0, 0);
    measure(1'b0, 1'b1, 20);
`ifdef TDC_AVG_EN
    measure(1'b0, 1'b1, 10);
    measure(1'b0, 1'b1, 30);
    measure(1'b0, 1'b1, 40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
